// File: rtl/valid_ready_fifo.sv
// valid_ready_fifo: first-word-fall-through FIFO with valid/ready handshakes
// on both sides. Buffers WIDTH-bit results from the gate datapath so the
// downstream consumer can stall without losing data. Flags depend only on
// registered state, so there are no combinational paths through the FIFO.
module valid_ready_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Refuse to elaborate with a depth the pointer arithmetic cannot wrap.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("valid_ready_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push, pop;
    logic [DEPTH-1:0] wr_sel;

    // Flags come straight from the stored count.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign out_data  = mem_q[rd_ptr_q];

    // A flush on the same edge discards any handshake.
    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // One-hot write select: the entry addressed by the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_q == PW'(gi));
        end
    endgenerate

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: cleared by reset so out_data reads zero afterwards; flush
    // leaves contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) mem_q[i] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Self-checking bench for valid_ready_fifo: directed phases plus randomized
// back-pressure, compared against a queue-based reference model.
module tb_valid_ready_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks;
    int failures;
    logic [WIDTH-1:0] model [$];

    valid_ready_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model's occupancy and head.
    task automatic check_outputs(input string tag);
        check({tag, ".count"},     64'(count),     64'(model.size()));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(model.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(model.size() != DEPTH));
        if (model.size() != 0) check({tag, ".out_data"}, out_data, model[0]);
    endtask

    // One clock: decide transfers from the model, clock, update, check.
    task automatic step(input string tag, output bit pushed, output bit popped);
        pushed = in_valid  && (model.size() < DEPTH) && !flush;
        popped = out_ready && (model.size() > 0)     && !flush;
        @(posedge clk);
        if (flush) model.delete();
        else begin
            if (popped) void'(model.pop_front());
            if (pushed) model.push_back(in_data);
        end
        @(negedge clk);
        check_outputs(tag);
        $display("[%0t] %s push=%0b pop=%0b count=%0d", $time, tag, pushed, popped, count);
    endtask

    initial begin
        bit pu, po;
        logic [63:0] exp_word;
        int rx_idx, tx_idx, k, max_cnt;

        checks = 0; failures = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held for three cycles, then idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.count",     64'(count),     64'd0);
        check("reset.out_data",  out_data,       64'd0);

        // Single word, visible the cycle after the push, then popped.
        in_valid = 1'b1; in_data = 64'hDEADBEEF_00000001; out_ready = 1'b0;
        step("single.push", pu, po);
        in_valid = 1'b0;
        check("single.data", out_data, 64'hDEADBEEF_00000001);
        out_ready = 1'b1;
        step("single.pop", pu, po);
        out_ready = 1'b0;
        check("single.empty", 64'(out_valid), 64'd0);

        // Fill, overflow attempt, drain: three rounds to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int v = 1; v <= 4; v++) begin
                in_valid = 1'b1; in_data = 64'(v);
                step("fill.push", pu, po);
            end
            check("fill.full_count", 64'(count), 64'd4);
            check("fill.full_ready", 64'(in_ready), 64'd0);
            in_data = 64'd5;
            step("fill.overflow", pu, po);
            step("fill.overflow", pu, po);
            check("fill.overflow_count", 64'(count), 64'd4);
            in_valid = 1'b0; out_ready = 1'b1;
            for (int v = 1; v <= 4; v++) begin
                check("fill.drain_order", out_data, 64'(v));
                step("fill.drain", pu, po);
            end
            check("fill.drained", 64'(out_valid), 64'd0);
            out_ready = 1'b0;
        end

        // Streaming: one word per cycle, count settles at 1.
        in_valid = 1'b1; in_data = 64'h10; out_ready = 1'b1; rx_idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (model.size() > 0) begin
                check("stream.order", out_data, 64'h10 + 64'(rx_idx));
                rx_idx++;
            end
            step("stream", pu, po);
            if (pu) in_data = in_data + 64'd1;
            if (c > 0) check("stream.count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        step("stream.tail", pu, po);
        out_ready = 1'b0;
        check("stream.no_gaps", 64'(rx_idx), 64'd19);

        // Back-pressure: 200 inverted indices against random out_ready.
        tx_idx = 0; rx_idx = 0; max_cnt = 0;
        in_valid = 1'b1; in_data = ~64'(0);
        for (k = 0; k < 3000 && rx_idx < 200; k++) begin
            out_ready = $urandom_range(0, 1) == 1;
            if (out_ready && model.size() > 0) begin
                exp_word = ~64'(rx_idx);
                check("bp.order", out_data, exp_word);
                rx_idx++;
            end
            step("bp", pu, po);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (pu) begin
                tx_idx++;
                if (tx_idx < 200) in_data = ~64'(tx_idx);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp.received", 64'(rx_idx), 64'd200);
        check("bp.max_count_le4", 64'(max_cnt <= DEPTH), 64'd1);

        // Flush with count=3 while a push and pop are both offered.
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; in_data = 64'hA0 + 64'(v);
            step("flush.fill", pu, po);
        end
        check("flush.pre_count", 64'(count), 64'd3);
        in_valid = 1'b1; in_data = 64'hBAD; out_ready = 1'b1; flush = 1'b1;
        step("flush", pu, po);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush.count", 64'(count), 64'd0);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        step("flush.idle", pu, po);
        in_valid = 1'b1; in_data = 64'hC0FFEE;
        step("flush.after_push", pu, po);
        in_valid = 1'b0;
        check("flush.absent", out_data, 64'hC0FFEE);
        out_ready = 1'b1;
        step("flush.after_pop", pu, po);
        out_ready = 1'b0;

        // Asynchronous reset pulsed between edges with count=2.
        for (int v = 0; v < 2; v++) begin
            in_valid = 1'b1; in_data = 64'hE0 + 64'(v);
            step("areset.fill", pu, po);
        end
        in_valid = 1'b0;
        check("areset.pre_count", 64'(count), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        model.delete();
        check("areset.count",     64'(count),     64'd0);
        check("areset.out_valid", 64'(out_valid), 64'd0);
        check("areset.in_ready",  64'(in_ready),  64'd1);
        check("areset.out_data",  out_data,       64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs("areset.post");
        in_valid = 1'b1; in_data = 64'h1234;
        step("areset.push", pu, po);
        in_valid = 1'b0; out_ready = 1'b1;
        step("areset.pop", pu, po);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
